// File: rtl/simon_playback_sequencer.sv
// ---------------------------------------------------------------------------
// simon_playback_sequencer
//
// Paced playback of the Simon pattern memory. When start arrives in IDLE,
// entries 0..count-1 are read in order. Each entry is shown on pattern_leds
// for the effective on-time and is then followed by a blank gap. A one-cycle
// done pulse marks the end of the sequence.
//
// Per-entry timeline: FETCH (1) -> LOAD (1) -> SHOW (on) -> GAP (GAP_CYCLES).
//
// Optional build macro: SIMON_PB_SPEEDUP_EN
//   When defined, on-time = max(ON_CYCLES - count, MIN_ON_CYCLES).
//   This value is fixed at start, so longer patterns play faster.
//   When undefined, on-time is always ON_CYCLES.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset; aborts without done
//   start         playback request, honoured only in IDLE
//   count         number of entries to play (0..2^ADDR_W), latched on start
//   mem_ren       pattern RAM read enable (FETCH only)
//   mem_raddr     pattern RAM read address (current entry index)
//   mem_rdata     pattern RAM data, valid one cycle after mem_ren
//   pattern_leds  displayed pattern, 0 when blank
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
// ---------------------------------------------------------------------------
module simon_playback_sequencer #(
    parameter int ADDR_W        = 5,
    parameter int ON_CYCLES     = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int MIN_ON_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [3:0]        mem_rdata,
    output logic [3:0]        pattern_leds,
    output logic              busy,
    output logic              done
);

    localparam int TMAX_OG = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMAX    = (TMAX_OG > MIN_ON_CYCLES) ? TMAX_OG : MIN_ON_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    localparam logic [TIMER_W-1:0] TMR_ONE = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] GAP_M1  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]    IDX_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHOW,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     index;
    logic [ADDR_W:0]     cnt_lat;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  on_m1;      // effective on-time minus one
    logic [3:0]          led_reg;
    logic                last_entry;

`ifdef SIMON_PB_SPEEDUP_EN
    // Signed subtraction, then a clamp to the floor. A long pattern gives a
    // negative difference, and the clamp handles it with no underflow.
    function automatic logic [TIMER_W-1:0] sat_on_time_m1(input logic [ADDR_W:0] cnt);
        logic signed [31:0] diff;
        diff = ON_CYCLES - $signed({1'b0, cnt});
        if (diff < MIN_ON_CYCLES) begin
            diff = MIN_ON_CYCLES;
        end
        return TIMER_W'(diff - 1);
    endfunction
`else
    assign on_m1 = TIMER_W'(ON_CYCLES - 1);
`endif

    // The end test runs before the increment, so index never wraps
    // when count = 2^ADDR_W.
    assign last_entry = ((index + IDX_ONE) == cnt_lat);
    assign mem_raddr  = index[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_ren      = 1'b0;
        pattern_leds = 4'h0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                mem_ren   = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SHOW;
            end
            S_SHOW: begin
                pattern_leds = led_reg;
                if (timer == '0) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_nxt = last_entry ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control counters: entry index, latched count and the phase timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index   <= '0;
            cnt_lat <= '0;
            timer   <= '0;
`ifdef SIMON_PB_SPEEDUP_EN
            on_m1   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_lat <= count;
                        index   <= '0;
`ifdef SIMON_PB_SPEEDUP_EN
                        on_m1   <= sat_on_time_m1(count);
`endif
                    end
                end
                S_LOAD: begin
                    timer <= on_m1;
                end
                S_SHOW: begin
                    if (timer == '0) begin
                        timer <= GAP_M1;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        if (!last_entry) begin
                            index <= index + IDX_ONE;
                        end
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // LED data register. It needs no reset because it only reaches the
    // output while the FSM is in SHOW.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            led_reg <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_simon_playback_sequencer.sv
module tb_simon_playback_sequencer;

    localparam int ADDR_W     = 5;
    localparam int ON_CYCLES  = 4;
    localparam int GAP_CYCLES = 2;
    localparam int MIN_ON     = 2;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [3:0]        mem_rdata = 4'h0;
    logic [3:0]        pattern_leds;
    logic              busy;
    logic              done;

    logic [3:0] ram [0:DEPTH-1];

    int vectors     = 0;
    int miscompares = 0;

    simon_playback_sequencer #(
        .ADDR_W       (ADDR_W),
        .ON_CYCLES    (ON_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .MIN_ON_CYCLES(MIN_ON)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .count       (count),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .pattern_leds(pattern_leds),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM: data appears one cycle after the read.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // On entry, the current time is cycle 0 of the run. Start is asserted
    // with the given count. mode 0 gives a clean run; mode 1 re-pulses
    // start at cycle 5 and changes count at cycle 6; mode 2 adds random
    // start/count noise for the whole run, done cycle included.
    task automatic run_playback(input int n, input int mode);
        int on, per, end_c, k, ph;
        logic e_busy, e_done, e_ren;
        logic [3:0] e_leds;
        on = ON_CYCLES;
`ifdef SIMON_PB_SPEEDUP_EN
        on = ON_CYCLES - n;
        if (on < MIN_ON) on = MIN_ON;
`endif
        per   = 2 + on + GAP_CYCLES;
        end_c = (n == 0) ? 1 : n * per + 1;
        start = 1'b1;
        count = (ADDR_W + 1)'(n);
        for (int t = 1; t <= end_c + 1; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 1) begin
                if (t == 5) start = 1'b1;
                if (t == 6) count = 7;
            end else if (mode == 2 && t <= end_c) begin
                start = ($urandom_range(0, 3) == 0);
                count = (ADDR_W + 1)'($urandom);
            end
            e_busy = (t <= end_c);
            e_done = (t == end_c);
            e_ren  = 1'b0;
            e_leds = 4'h0;
            k      = 0;
            if (n > 0 && t < end_c) begin
                k  = (t - 1) / per;
                ph = (t - 1) % per;
                e_ren = (ph == 0);
                if (ph >= 2 && ph < 2 + on) e_leds = ram[k];
            end
            check_eq("busy", 32'(busy), 32'(e_busy));
            check_eq("done", 32'(done), 32'(e_done));
            check_eq("mem_ren", 32'(mem_ren), 32'(e_ren));
            check_eq("pattern_leds", 32'(pattern_leds), 32'(e_leds));
            if (e_ren) check_eq("mem_raddr", 32'(mem_raddr), 32'(k));
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_ren", 32'(mem_ren), 0);
        check_eq("rst_raddr", 32'(mem_raddr), 0);
        check_eq("rst_leds", 32'(pattern_leds), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Three-entry run.
        ram[0] = 4'h1; ram[1] = 4'h2; ram[2] = 4'h4;
        run_playback(3, 0);
        // An empty pattern completes immediately.
        run_playback(0, 0);
        // A second start and a count change mid-run have no effect.
        run_playback(3, 1);

        // Asynchronous reset during SHOW of entry 1 (cycle 12).
        start = 1'b1; count = 3;
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq("pre_rst_leds", 32'(pattern_leds), 32'h2);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_leds", 32'(pattern_leds), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_ren", 32'(mem_ren), 0);
        check_eq("arst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            check_eq("post_rst_done", 32'(done), 0);
            check_eq("post_rst_busy", 32'(busy), 0);
        end
        run_playback(3, 0);

        // Full memory: every address, no wrap.
        for (int i = 0; i < DEPTH; i++) ram[i] = 4'(i);
        run_playback(DEPTH, 0);

        // Randomized runs with random idle spacing and input noise.
        for (int r = 0; r < 12; r++) begin
            int n;
            for (int i = 0; i < DEPTH; i++) ram[i] = 4'($urandom);
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = 1;
                2:       n = $urandom_range(20, DEPTH);
                default: n = $urandom_range(2, 10);
            endcase
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
                check_eq("idle_busy", 32'(busy), 0);
            end
            run_playback(n, ($urandom_range(0, 1) == 1) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
